// File: rtl/id_type_i_if.sv
// Bundle of the fetch, register-file, writeback, execute and illegal-pulse signals around the
// I-type decode/issue stage. Member names are taken from the stage's point of view.
interface id_type_i_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [DATA_W-1:0] inst_i;
  logic              inst_valid_i;
  logic              inst_ready_o;
  logic              reg_re_o;
  logic [ADDR_W-1:0] reg_raddr_o;
  logic [DATA_W-1:0] reg_rdata_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_waddr_i;
  logic [DATA_W-1:0] wb_wdata_i;
  logic [DATA_W-1:0] op1_o;
  logic [DATA_W-1:0] op2_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] rd_o;
  logic              valid_o;
  logic              ready_i;
  logic              illegal_o;

  modport slave (
    input  inst_i, inst_valid_i, reg_rdata_i, wb_we_i, wb_waddr_i, wb_wdata_i, ready_i,
    output inst_ready_o, reg_re_o, reg_raddr_o, op1_o, op2_o, inst_o, rd_o, valid_o, illegal_o
  );

  modport master (
    output inst_i, inst_valid_i, reg_rdata_i, wb_we_i, wb_waddr_i, wb_wdata_i, ready_i,
    input  inst_ready_o, reg_re_o, reg_raddr_o, op1_o, op2_o, inst_o, rd_o, valid_o, illegal_o
  );
endinterface

// File: rtl/id_type_i.sv
// I-type decode/issue stage: accepts an instruction, reads rs1 (with writeback forwarding),
// builds the immediate, and holds op1/op2/inst/rd for execute until it accepts them.
module id_type_i #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  id_type_i_if.slave    bus
);

  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t state;

  // Shift-immediates carry a 5-bit shamt (upper bits are funct7); all others sign-extend imm[11:0].
  function automatic logic signed [DATA_W-1:0] imm_gen(input logic [DATA_W-1:0] inst);
    logic [2:0] f3;
    f3 = inst[14:12];
    if (f3 == 3'b001 || f3 == 3'b101)
      imm_gen = {{(DATA_W-5){1'b0}}, inst[24:20]};
    else
      imm_gen = {{(DATA_W-12){inst[31]}}, inst[31:20]};
  endfunction

  logic [6:0]        opcode;
  logic [ADDR_W-1:0] rs1_a;
  logic              is_itype;
  logic              rs1_nz;
  logic              inst_ready;
  logic              accept;
  logic              accept_i;
  logic              accept_bad;
  logic              wb_hit_a;
  logic              wb_hit_r;

  // Accept-cycle latches feeding the READ stage
  logic        [DATA_W-1:0] inst_p0;
  logic        [ADDR_W-1:0] rs1_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic        [DATA_W-1:0] fwd_data_p0;
  logic                     fwd_vld_p0;

  logic [DATA_W-1:0] op1_sel;

  // Registered execute-side outputs
  logic [DATA_W-1:0] op1_p1;
  logic [DATA_W-1:0] op2_p1;
  logic [DATA_W-1:0] inst_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic              vld_p1;
  logic              illegal_p1;

  assign opcode     = bus.inst_i[6:0];
  assign rs1_a      = bus.inst_i[19:15];
  assign is_itype   = (opcode == OPC_ITYPE);
  assign rs1_nz     = (rs1_a != '0);
  assign inst_ready = (state == IDLE) || ((state == HOLD) && bus.ready_i);
  assign accept     = bus.inst_valid_i && inst_ready;
  assign accept_i   = accept && is_itype;
  assign accept_bad = accept && !is_itype;

  // Writes to x0 never forward, so both hit terms require a nonzero rs1.
  assign wb_hit_a = bus.wb_we_i && (bus.wb_waddr_i == rs1_a) && rs1_nz;
  assign wb_hit_r = bus.wb_we_i && (bus.wb_waddr_i == rs1_p0) && (rs1_p0 != '0);

  assign bus.inst_ready_o = inst_ready;
  assign bus.reg_raddr_o  = rs1_a;
  assign bus.reg_re_o     = accept_i && rs1_nz;

  assign bus.op1_o     = op1_p1;
  assign bus.op2_o     = op2_p1;
  assign bus.inst_o    = inst_p1;
  assign bus.rd_o      = rd_p1;
  assign bus.valid_o   = vld_p1;
  assign bus.illegal_o = illegal_p1;

  // ---- accept -> READ boundary ----
  always_ff @(posedge clk_i) begin
    if (accept_i) begin
      inst_p0     <= bus.inst_i;
      rs1_p0      <= rs1_a;
      imm_p0      <= imm_gen(bus.inst_i);
      fwd_data_p0 <= bus.wb_wdata_i;
    end
  end

  // The register file returns the pre-write value for an accept-cycle write, hence the latched copy.
  always_comb begin
    op1_sel = bus.reg_rdata_i;
    if (rs1_p0 == '0)
      op1_sel = '0;
    else if (wb_hit_r)
      op1_sel = bus.wb_wdata_i;
    else if (fwd_vld_p0)
      op1_sel = fwd_data_p0;
  end

  // ---- READ -> HOLD boundary (execute-facing registers) ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      fwd_vld_p0 <= 1'b0;
      op1_p1     <= '0;
      op2_p1     <= '0;
      inst_p1    <= '0;
      rd_p1      <= '0;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= accept_bad;
      if (accept_i)
        fwd_vld_p0 <= wb_hit_a;

      case (state)
        IDLE: begin
          if (accept_i)
            state <= READ;
        end
        READ: begin
          op1_p1  <= op1_sel;
          op2_p1  <= imm_p0;
          inst_p1 <= inst_p0;
          rd_p1   <= inst_p0[11:7];
          vld_p1  <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (wb_hit_r)
            op1_p1 <= bus.wb_wdata_i;
          if (bus.ready_i) begin
            vld_p1 <= 1'b0;
            state  <= accept_i ? READ : IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_type_i.sv
// Directed bench for the I-type decode/issue stage: forwarding paths, immediates, hold, illegal, reset.
module tb_id_type_i;

  logic clk_i;
  logic rst_n_i;
  int   checks;
  int   errors;

  logic [31:0] rf [0:31];

  id_type_i_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  id_type_i #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One-cycle-latency register file; it never sees writeback, so it returns stale data.
  always @(posedge clk_i) begin
    if (bus.reg_re_o)
      bus.reg_rdata_i <= rf[bus.reg_raddr_o];
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.inst_i       = 32'h0;
    bus.inst_valid_i = 1'b0;
    bus.wb_we_i      = 1'b0;
    bus.wb_waddr_i   = 5'd0;
    bus.wb_wdata_i   = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[2] = 32'd5;
    rf[4] = 32'h10;
    idle_inputs();
    bus.ready_i = 1'b1;
    rst_n_i = 1'b0;
    #3;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    chk("rst_op1", bus.op1_o, 0);
    chk("rst_inst", bus.inst_o, 0);
    chk("rst_ready", bus.inst_ready_o, 1);
    tick();
    tick();
    rst_n_i = 1'b1;
    tick();

    // ADDI x1,x2,-1
    bus.inst_i = 32'hFFF10093; bus.inst_valid_i = 1'b1;
    #1;
    chk("addi_raddr", bus.reg_raddr_o, 2);
    chk("addi_re", bus.reg_re_o, 1);
    tick();
    idle_inputs();
    chk("addi_read_valid", bus.valid_o, 0);
    chk("addi_read_ready", bus.inst_ready_o, 0);
    tick();
    chk("addi_valid", bus.valid_o, 1);
    chk("addi_op1", bus.op1_o, 32'd5);
    chk("addi_op2", bus.op2_o, 32'hFFFFFFFF);
    chk("addi_rd", bus.rd_o, 1);
    chk("addi_inst", bus.inst_o, 32'hFFF10093);
    chk("addi_illegal", bus.illegal_o, 0);
    tick();
    chk("addi_done_valid", bus.valid_o, 0);
    chk("addi_done_ready", bus.inst_ready_o, 1);

    // SRAI x3,x4,4
    bus.inst_i = 32'h40425193; bus.inst_valid_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("srai_valid", bus.valid_o, 1);
    chk("srai_op2", bus.op2_o, 32'h4);
    chk("srai_funct7", {25'h0, bus.inst_o[31:25]}, 32'h20);
    chk("srai_op1", bus.op1_o, 32'h10);
    chk("srai_rd", bus.rd_o, 3);
    tick();

    // ADDI x5,x7,1 with writeback x7 in the accept cycle
    bus.inst_i = 32'h00138293; bus.inst_valid_i = 1'b1;
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd7; bus.wb_wdata_i = 32'hABCD;
    tick();
    idle_inputs();
    tick();
    chk("fwd_acc_op1", bus.op1_o, 32'hABCD);
    chk("fwd_acc_op2", bus.op2_o, 32'h1);
    tick();

    // Same instruction, writeback during READ
    bus.inst_i = 32'h00138293; bus.inst_valid_i = 1'b1;
    tick();
    idle_inputs();
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd7; bus.wb_wdata_i = 32'hABCD;
    tick();
    idle_inputs();
    chk("fwd_read_op1", bus.op1_o, 32'hABCD);
    tick();

    // ADDI x1,x0,5 with a writeback to x0 that must not forward
    bus.inst_i = 32'h00500093; bus.inst_valid_i = 1'b1;
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd0; bus.wb_wdata_i = 32'hDEAD;
    #1;
    chk("x0_re", bus.reg_re_o, 0);
    tick();
    tick();
    idle_inputs();
    chk("x0_op1", bus.op1_o, 0);
    chk("x0_op2", bus.op2_o, 32'd5);
    tick();

    // Hold with ready_i=0, writeback x2=9 during HOLD, then hand-off to SRAI
    bus.ready_i = 1'b0;
    bus.inst_i = 32'hFFF10093; bus.inst_valid_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("hold_valid0", bus.valid_o, 1);
    chk("hold_op1_0", bus.op1_o, 32'd5);
    bus.inst_i = 32'h40425193; bus.inst_valid_i = 1'b1;
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd2; bus.wb_wdata_i = 32'd9;
    #1;
    chk("hold_ready0", bus.inst_ready_o, 0);
    chk("hold_re0", bus.reg_re_o, 0);
    tick();
    bus.wb_we_i = 1'b0;
    chk("hold_valid1", bus.valid_o, 1);
    chk("hold_op1_1", bus.op1_o, 32'd9);
    chk("hold_ready1", bus.inst_ready_o, 0);
    tick();
    chk("hold_valid2", bus.valid_o, 1);
    chk("hold_inst2", bus.inst_o, 32'hFFF10093);
    bus.ready_i = 1'b1;
    #1;
    chk("handoff_ready", bus.inst_ready_o, 1);
    tick();
    idle_inputs();
    chk("handoff_drop", bus.valid_o, 0);
    tick();
    chk("handoff_valid", bus.valid_o, 1);
    chk("handoff_op2", bus.op2_o, 32'h4);
    chk("handoff_op1", bus.op1_o, 32'h10);
    tick();
    chk("handoff_done", bus.valid_o, 0);

    // R-type: dropped with a single illegal pulse
    bus.inst_i = 32'h002081B3; bus.inst_valid_i = 1'b1;
    #1;
    chk("rtype_re", bus.reg_re_o, 0);
    tick();
    idle_inputs();
    chk("rtype_illegal", bus.illegal_o, 1);
    chk("rtype_valid", bus.valid_o, 0);
    chk("rtype_state", bus.inst_ready_o, 1);
    tick();
    chk("rtype_illegal_end", bus.illegal_o, 0);
    chk("rtype_valid_end", bus.valid_o, 0);

    // Reset asserted during READ
    bus.inst_i = 32'hFFF10093; bus.inst_valid_i = 1'b1;
    tick();
    idle_inputs();
    rst_n_i = 1'b0;
    #1;
    chk("rstr_valid", bus.valid_o, 0);
    chk("rstr_op2", bus.op2_o, 0);
    chk("rstr_inst", bus.inst_o, 0);
    chk("rstr_rd", bus.rd_o, 0);
    chk("rstr_op1", bus.op1_o, 0);
    tick();
    rst_n_i = 1'b1;
    tick();
    chk("rstr_discard", bus.valid_o, 0);
    chk("rstr_ready", bus.inst_ready_o, 1);
    bus.inst_i = 32'hFFF10093; bus.inst_valid_i = 1'b1;
    tick();
    idle_inputs();
    chk("post_rst_lat1", bus.valid_o, 0);
    tick();
    chk("post_rst_valid", bus.valid_o, 1);
    chk("post_rst_op1", bus.op1_o, 32'd5);
    chk("post_rst_op2", bus.op2_o, 32'hFFFFFFFF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
